// File: rtl/ulpi_link.sv
// rtl/ulpi_link.sv - ULPI link layer: register access, TX packets and RX decode over an 8-bit ULPI bus.
module ulpi_link (
  input  logic       clk,
  input  logic       rst,
  input  logic       dir,
  input  logic       nxt,
  output logic       stp,
  inout  wire  [7:0] data,
  input  logic       reg_req,
  input  logic       reg_we,
  input  logic [5:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic       reg_ack,
  output logic [7:0] reg_rdata,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_abort,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [7:0] rx_cmd,
  output logic       rx_cmd_valid,
  output logic       rx_active
);

  typedef enum logic [3:0] {
    IDLE, TX_CMD, TX_DATA, TX_STP, REG_CMD, REG_WDATA, REG_STP, REG_TA, REG_RDATA
  } state_t;

  state_t     state;
  logic       dir_q;
  logic       own;
  logic       consume;
  logic [7:0] data_out;

  // The link may drive only after the bus has been ours for a full cycle.
  assign own      = !dir && !dir_q;
  assign data     = own ? data_out : 8'hzz;
  assign stp      = !rst && (state == TX_STP || state == REG_STP);
  assign tx_ready = !rst && own && nxt &&
                    (state == TX_CMD || (state == TX_DATA && tx_valid));
  assign consume  = tx_ready && tx_valid;

  always_comb begin
    data_out = 8'h00;
    if (!rst) begin
      case (state)
        TX_CMD:    data_out = {4'b0100, tx_data[3:0]};
        TX_DATA:   if (tx_valid) data_out = tx_data;
        REG_CMD:   data_out = {1'b1, !reg_we, reg_addr};
        REG_WDATA: data_out = reg_wdata;
        default:   data_out = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      dir_q        <= 1'b0;
      reg_ack      <= 1'b0;
      reg_rdata    <= 8'h00;
      tx_abort     <= 1'b0;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_cmd       <= 8'h00;
      rx_cmd_valid <= 1'b0;
      rx_active    <= 1'b0;
    end else begin
      dir_q        <= dir;
      reg_ack      <= 1'b0;
      tx_abort     <= 1'b0;
      rx_valid     <= 1'b0;
      rx_cmd_valid <= 1'b0;

      // The register read byte belongs to the register port, not the RX stream.
      if (dir && dir_q && state != REG_RDATA) begin
        if (nxt) begin
          rx_data  <= data;
          rx_valid <= 1'b1;
        end else begin
          rx_cmd       <= data;
          rx_cmd_valid <= 1'b1;
        end
      end

      if (!dir)
        rx_active <= 1'b0;
      else if (!dir_q && nxt)
        rx_active <= 1'b1;

      case (state)
        IDLE: begin
          if (own && !reg_ack) begin
            if (reg_req)       state <= REG_CMD;
            else if (tx_valid) state <= TX_CMD;
          end
        end
        TX_CMD, TX_DATA: begin
          if (dir) begin
            tx_abort <= 1'b1;
            state    <= IDLE;
          end else if (consume) begin
            state <= tx_last ? TX_STP : TX_DATA;
          end
        end
        TX_STP: begin
          if (dir) tx_abort <= 1'b1;
          state <= IDLE;
        end
        // A dir-induced abort leaves reg_req pending, so IDLE retries it.
        REG_CMD: begin
          if (dir)      state <= IDLE;
          else if (nxt) state <= reg_we ? REG_WDATA : REG_TA;
        end
        REG_WDATA: begin
          if (dir) begin
            state <= IDLE;
          end else if (nxt) begin
            state   <= REG_STP;
            reg_ack <= 1'b1;
          end
        end
        REG_STP: state <= IDLE;
        REG_TA: begin
          if (dir && !dir_q) state <= REG_RDATA;
        end
        REG_RDATA: begin
          state <= IDLE;
          if (dir) begin
            reg_rdata <= data;
            reg_ack   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ulpi_link.sv
// tb/tb_ulpi_link.sv - directed vector bench for ulpi_link.
module tb_ulpi_link;

  logic       clk = 1'b0;
  logic       rst, dir, nxt, pdrv;
  logic [7:0] pval;
  logic       reg_req, reg_we;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       tx_valid, tx_last;
  logic [7:0] tx_data;
  wire  [7:0] data;
  logic       stp, reg_ack, tx_ready, tx_abort, rx_valid, rx_cmd_valid, rx_active;
  logic [7:0] reg_rdata, rx_data, rx_cmd;

  int checks = 0;
  int failures = 0;
  int cur = 0;

  always #5 clk = ~clk;

  // Released bus reads back as 8'hFF.
  assign data = pdrv ? pval : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup pu (data[g]);
  end

  ulpi_link dut (
    .clk(clk), .rst(rst), .dir(dir), .nxt(nxt), .stp(stp), .data(data),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_ack(reg_ack), .reg_rdata(reg_rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
    .tx_ready(tx_ready), .tx_abort(tx_abort),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_cmd(rx_cmd),
    .rx_cmd_valid(rx_cmd_valid), .rx_active(rx_active)
  );

  // ctl = {rst,dir,nxt,phy_drives}; rq = {reg_req,reg_we}; tx = {tx_valid,tx_last}
  // flg = {stp,reg_ack,tx_ready,tx_abort,rx_valid,rx_cmd_valid,rx_active}
  typedef struct {
    logic [3:0] ctl;
    logic [7:0] pval;
    logic [1:0] rq;
    logic [5:0] ra;
    logic [7:0] rw;
    logic [1:0] tx;
    logic [7:0] td;
    logic [7:0] ed;
    logic [6:0] flg;
    logic [7:0] erd, erxd, ercmd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] ctl, input logic [7:0] pv, input logic [1:0] rq,
                              input logic [5:0] ra, input logic [7:0] rw, input logic [1:0] tx,
                              input logic [7:0] td, input logic [7:0] ed, input logic [6:0] flg,
                              input logic [7:0] erd, input logic [7:0] erxd, input logic [7:0] ercmd);
    vec_t v;
    v.ctl = ctl; v.pval = pv; v.rq = rq; v.ra = ra; v.rw = rw; v.tx = tx; v.td = td;
    v.ed = ed; v.flg = flg; v.erd = erd; v.erxd = erxd; v.ercmd = ercmd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %02h expected %02h", name, cur, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    {rst, dir, nxt, pdrv} = v.ctl;
    pval = v.pval;
    {reg_req, reg_we} = v.rq;
    reg_addr = v.ra;
    reg_wdata = v.rw;
    {tx_valid, tx_last} = v.tx;
    tx_data = v.td;
  endtask

  task automatic check_row(input vec_t v);
    chk("data", data, v.ed);
    chk("stp", {7'b0, stp}, {7'b0, v.flg[6]});
    chk("reg_ack", {7'b0, reg_ack}, {7'b0, v.flg[5]});
    chk("tx_ready", {7'b0, tx_ready}, {7'b0, v.flg[4]});
    chk("tx_abort", {7'b0, tx_abort}, {7'b0, v.flg[3]});
    chk("rx_valid", {7'b0, rx_valid}, {7'b0, v.flg[2]});
    chk("rx_cmd_valid", {7'b0, rx_cmd_valid}, {7'b0, v.flg[1]});
    chk("rx_active", {7'b0, rx_active}, {7'b0, v.flg[0]});
    chk("reg_rdata", reg_rdata, v.erd);
    chk("rx_data", rx_data, v.erxd);
    chk("rx_cmd", rx_cmd, v.ercmd);
  endtask

  initial begin
    logic [7:0] seen[$];
    logic       ack_seen;

    // reset, then register write 0x0A <= 0x45
    tbl.push_back(mk(4'b1000, 8'h00, 2'b00, 6'h00, 8'h00, 2'b00, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0000, 8'h00, 2'b11, 6'h0A, 8'h45, 2'b00, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0000, 8'h00, 2'b11, 6'h0A, 8'h45, 2'b00, 8'h00, 8'h8A, 7'b0000000, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0010, 8'h00, 2'b11, 6'h0A, 8'h45, 2'b00, 8'h00, 8'h8A, 7'b0000000, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0000, 8'h00, 2'b11, 6'h0A, 8'h45, 2'b00, 8'h00, 8'h45, 7'b0000000, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0010, 8'h00, 2'b11, 6'h0A, 8'h45, 2'b00, 8'h00, 8'h45, 7'b0000000, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0000, 8'h00, 2'b11, 6'h0A, 8'h45, 2'b00, 8'h00, 8'h00, 7'b1100000, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0000, 8'h00, 2'b00, 6'h0A, 8'h45, 2'b00, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00, 8'h00));
    // register read 0x16, PHY returns 0x5A
    tbl.push_back(mk(4'b0000, 8'h00, 2'b10, 6'h16, 8'h00, 2'b00, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0010, 8'h00, 2'b10, 6'h16, 8'h00, 2'b00, 8'h00, 8'hD6, 7'b0000000, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0100, 8'h00, 2'b10, 6'h16, 8'h00, 2'b00, 8'h00, 8'hFF, 7'b0000000, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0101, 8'h5A, 2'b10, 6'h16, 8'h00, 2'b00, 8'h00, 8'h5A, 7'b0000000, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0000, 8'h00, 2'b10, 6'h16, 8'h00, 2'b00, 8'h00, 8'hFF, 7'b0100000, 8'h5A, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0000, 8'h00, 2'b00, 6'h16, 8'h00, 2'b00, 8'h00, 8'h00, 7'b0000000, 8'h5A, 8'h00, 8'h00));
    // TX packet C3,11,22 with nxt high
    tbl.push_back(mk(4'b0010, 8'h00, 2'b00, 6'h00, 8'h00, 2'b10, 8'hC3, 8'h00, 7'b0000000, 8'h5A, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0010, 8'h00, 2'b00, 6'h00, 8'h00, 2'b10, 8'hC3, 8'h43, 7'b0010000, 8'h5A, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0010, 8'h00, 2'b00, 6'h00, 8'h00, 2'b10, 8'h11, 8'h11, 7'b0010000, 8'h5A, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0010, 8'h00, 2'b00, 6'h00, 8'h00, 2'b11, 8'h22, 8'h22, 7'b0010000, 8'h5A, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0010, 8'h00, 2'b00, 6'h00, 8'h00, 2'b00, 8'h00, 8'h00, 7'b1000000, 8'h5A, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0000, 8'h00, 2'b00, 6'h00, 8'h00, 2'b00, 8'h00, 8'h00, 7'b0000000, 8'h5A, 8'h00, 8'h00));
    // receive: turnaround with nxt, data A5, RX CMD 4E, dir drops
    tbl.push_back(mk(4'b0110, 8'h00, 2'b00, 6'h00, 8'h00, 2'b00, 8'h00, 8'hFF, 7'b0000000, 8'h5A, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0111, 8'hA5, 2'b00, 6'h00, 8'h00, 2'b00, 8'h00, 8'hA5, 7'b0000001, 8'h5A, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0101, 8'h4E, 2'b00, 6'h00, 8'h00, 2'b00, 8'h00, 8'h4E, 7'b0000101, 8'h5A, 8'hA5, 8'h00));
    tbl.push_back(mk(4'b0000, 8'h00, 2'b00, 6'h00, 8'h00, 2'b00, 8'h00, 8'hFF, 7'b0000011, 8'h5A, 8'hA5, 8'h4E));
    tbl.push_back(mk(4'b0000, 8'h00, 2'b00, 6'h00, 8'h00, 2'b00, 8'h00, 8'h00, 7'b0000000, 8'h5A, 8'hA5, 8'h4E));
    // TX stalled by tx_valid=0, then aborted by dir in TX_DATA
    tbl.push_back(mk(4'b0000, 8'h00, 2'b00, 6'h00, 8'h00, 2'b10, 8'hC3, 8'h00, 7'b0000000, 8'h5A, 8'hA5, 8'h4E));
    tbl.push_back(mk(4'b0010, 8'h00, 2'b00, 6'h00, 8'h00, 2'b10, 8'hC3, 8'h43, 7'b0010000, 8'h5A, 8'hA5, 8'h4E));
    tbl.push_back(mk(4'b0000, 8'h00, 2'b00, 6'h00, 8'h00, 2'b10, 8'h11, 8'h11, 7'b0000000, 8'h5A, 8'hA5, 8'h4E));
    tbl.push_back(mk(4'b0010, 8'h00, 2'b00, 6'h00, 8'h00, 2'b00, 8'h11, 8'h00, 7'b0000000, 8'h5A, 8'hA5, 8'h4E));
    tbl.push_back(mk(4'b0100, 8'h00, 2'b00, 6'h00, 8'h00, 2'b10, 8'h11, 8'hFF, 7'b0000000, 8'h5A, 8'hA5, 8'h4E));
    tbl.push_back(mk(4'b0101, 8'h2C, 2'b00, 6'h00, 8'h00, 2'b00, 8'h00, 8'h2C, 7'b0001000, 8'h5A, 8'hA5, 8'h4E));
    tbl.push_back(mk(4'b0000, 8'h00, 2'b00, 6'h00, 8'h00, 2'b00, 8'h00, 8'hFF, 7'b0000010, 8'h5A, 8'hA5, 8'h2C));
    tbl.push_back(mk(4'b0000, 8'h00, 2'b00, 6'h00, 8'h00, 2'b00, 8'h00, 8'h00, 7'b0000000, 8'h5A, 8'hA5, 8'h2C));
    // reset in REG_WDATA, then a clean write
    tbl.push_back(mk(4'b0000, 8'h00, 2'b11, 6'h0A, 8'h45, 2'b00, 8'h00, 8'h00, 7'b0000000, 8'h5A, 8'hA5, 8'h2C));
    tbl.push_back(mk(4'b0010, 8'h00, 2'b11, 6'h0A, 8'h45, 2'b00, 8'h00, 8'h8A, 7'b0000000, 8'h5A, 8'hA5, 8'h2C));
    tbl.push_back(mk(4'b0000, 8'h00, 2'b11, 6'h0A, 8'h45, 2'b00, 8'h00, 8'h45, 7'b0000000, 8'h5A, 8'hA5, 8'h2C));
    tbl.push_back(mk(4'b1010, 8'h00, 2'b11, 6'h0A, 8'h45, 2'b00, 8'h00, 8'h00, 7'b0000000, 8'h5A, 8'hA5, 8'h2C));
    tbl.push_back(mk(4'b0000, 8'h00, 2'b11, 6'h0A, 8'h45, 2'b00, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0000, 8'h00, 2'b11, 6'h0A, 8'h45, 2'b00, 8'h00, 8'h8A, 7'b0000000, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0010, 8'h00, 2'b11, 6'h0A, 8'h45, 2'b00, 8'h00, 8'h8A, 7'b0000000, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0010, 8'h00, 2'b11, 6'h0A, 8'h45, 2'b00, 8'h00, 8'h45, 7'b0000000, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0000, 8'h00, 2'b11, 6'h0A, 8'h45, 2'b00, 8'h00, 8'h00, 7'b1100000, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0000, 8'h00, 2'b00, 6'h0A, 8'h45, 2'b00, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00, 8'h00));
    // reg_req beats tx_valid; dir aborts REG_CMD, request retried
    tbl.push_back(mk(4'b0000, 8'h00, 2'b11, 6'h0A, 8'h45, 2'b10, 8'hC3, 8'h00, 7'b0000000, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0000, 8'h00, 2'b11, 6'h0A, 8'h45, 2'b10, 8'hC3, 8'h8A, 7'b0000000, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0100, 8'h00, 2'b11, 6'h0A, 8'h45, 2'b10, 8'hC3, 8'hFF, 7'b0000000, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0101, 8'h3F, 2'b11, 6'h0A, 8'h45, 2'b10, 8'hC3, 8'h3F, 7'b0000000, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(4'b0000, 8'h00, 2'b11, 6'h0A, 8'h45, 2'b10, 8'hC3, 8'hFF, 7'b0000010, 8'h00, 8'h00, 8'h3F));
    tbl.push_back(mk(4'b0000, 8'h00, 2'b11, 6'h0A, 8'h45, 2'b10, 8'hC3, 8'h00, 7'b0000000, 8'h00, 8'h00, 8'h3F));
    tbl.push_back(mk(4'b0010, 8'h00, 2'b11, 6'h0A, 8'h45, 2'b10, 8'hC3, 8'h8A, 7'b0000000, 8'h00, 8'h00, 8'h3F));
    tbl.push_back(mk(4'b0010, 8'h00, 2'b11, 6'h0A, 8'h45, 2'b10, 8'hC3, 8'h45, 7'b0000000, 8'h00, 8'h00, 8'h3F));
    tbl.push_back(mk(4'b0000, 8'h00, 2'b11, 6'h0A, 8'h45, 2'b10, 8'hC3, 8'h00, 7'b1100000, 8'h00, 8'h00, 8'h3F));
    tbl.push_back(mk(4'b0000, 8'h00, 2'b00, 6'h0A, 8'h45, 2'b00, 8'hC3, 8'h00, 7'b0000000, 8'h00, 8'h00, 8'h3F));

    apply(tbl[0]);
    repeat (2) cyc();

    for (int i = 0; i < tbl.size(); i++) begin
      cur = i;
      cyc();
      apply(tbl[i]);
      #1;
      check_row(tbl[i]);
    end

    // one-byte packet: TX_CMD straight to TX_STP
    cur = 100;
    cyc(); nxt = 1'b1; tx_valid = 1'b1; tx_data = 8'h2D; tx_last = 1'b1; #1;
    chk("one_idle_data", data, 8'h00);
    cyc(); #1;
    chk("one_cmd_data", data, 8'h4D);
    chk("one_cmd_ready", {7'b0, tx_ready}, 8'h01);
    cyc(); tx_valid = 1'b0; tx_last = 1'b0; #1;
    chk("one_stp", {7'b0, stp}, 8'h01);
    chk("one_stp_data", data, 8'h00);
    cyc(); nxt = 1'b0; #1;
    chk("one_idle_stp", {7'b0, stp}, 8'h00);

    // write 0x3F <= 0xE7 with a slow PHY (nxt every third cycle), bounded wait for reg_ack
    cur = 200;
    ack_seen = 1'b0;
    reg_we = 1'b1; reg_addr = 6'h3F; reg_wdata = 8'hE7;
    for (int k = 0; k < 30 && !ack_seen; k++) begin
      cyc();
      reg_req = 1'b1;
      nxt = (k % 3 == 2);
      #1;
      if (nxt && !stp) seen.push_back(data);
      if (reg_ack) begin
        ack_seen = 1'b1;
        chk("slow_stp_with_ack", {7'b0, stp}, 8'h01);
      end
    end
    chk("slow_ack_within_budget", {7'b0, ack_seen}, 8'h01);
    chk("slow_byte_count", 8'(seen.size()), 8'h02);
    if (seen.size() == 2) begin
      chk("slow_cmd_byte", seen[0], 8'hBF);
      chk("slow_wdata_byte", seen[1], 8'hE7);
    end
    cyc(); reg_req = 1'b0; nxt = 1'b0; #1;
    chk("slow_ack_cleared", {7'b0, reg_ack}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
